// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_LOAD  = 3'b001,
        ST_ADD   = 3'b010,
        ST_SHIFT = 3'b011,
        ST_DONE  = 3'b100
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10
    } booth_op_e;

    function automatic int unsigned booth_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    // Booth recoding of the current multiplier bit pair {Q[0], q_1}.
    function automatic booth_op_e booth_op(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b10:   return OP_SUB;
            2'b01:   return OP_ADD;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/unidad_control_booth.sv
// Booth multiplier control: FSM, iteration counter and registered datapath strobes.
module unidad_control_booth
    import booth_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = booth_clog2(N + 2)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [1:0] q_lsb_i,
    input  logic       q_1_i,
    input  logic       mplier_b0_i,
    output logic       listo_o,
    output logic       busy_o,
    output logic       carga_m_o,
    output logic       carga_q_o,
    output logic       carga_a_o,
    output logic       resta_a_o,
    output logic       desplaza_aq_o,
    output logic       ultimo_o,
    output logic       fin_o
);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    booth_op_e       op_load_c;
    booth_op_e       op_shift_c;

    // Strobes are registered, so the op for the coming ADD is predicted from
    // the bit pair that will be in place after the current LOAD or SHIFT.
    assign op_load_c  = booth_op(mplier_b0_i, 1'b0);
    assign op_shift_c = booth_op(q_lsb_i[1], q_lsb_i[0]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            listo_o       <= 1'b1;
            busy_o        <= 1'b0;
            carga_m_o     <= 1'b0;
            carga_q_o     <= 1'b0;
            carga_a_o     <= 1'b0;
            resta_a_o     <= 1'b0;
            desplaza_aq_o <= 1'b0;
            ultimo_o      <= 1'b0;
            fin_o         <= 1'b0;
        end else begin
            carga_m_o     <= 1'b0;
            carga_q_o     <= 1'b0;
            carga_a_o     <= 1'b0;
            resta_a_o     <= 1'b0;
            desplaza_aq_o <= 1'b0;
            ultimo_o      <= 1'b0;
            fin_o         <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_q   <= ST_LOAD;
                        carga_m_o <= 1'b1;
                        carga_q_o <= 1'b1;
                        busy_o    <= 1'b1;
                        listo_o   <= 1'b0;
                    end else begin
                        state_q   <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_q   <= ST_ADD;
                    cnt_q     <= '0;
                    carga_a_o <= (op_load_c != OP_NONE);
                    resta_a_o <= (op_load_c == OP_SUB);
                end
                ST_ADD: begin
                    state_q       <= ST_SHIFT;
                    desplaza_aq_o <= 1'b1;
                    ultimo_o      <= (cnt_q == CW'(N));
                end
                ST_SHIFT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N)) begin
                        state_q <= ST_DONE;
                        fin_o   <= 1'b1;
                        busy_o  <= 1'b0;
                        listo_o <= 1'b1;
                    end else begin
                        state_q   <= ST_ADD;
                        carga_a_o <= (op_shift_c != OP_NONE);
                        resta_a_o <= (op_shift_c == OP_SUB);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_o  <= 1'b0;
                    listo_o <= 1'b1;
                end
            endcase
        end
    end

    // q_1 is folded into the prediction through q_lsb_i[0]; kept as a port for
    // visibility of the full Booth pair at the boundary.
    logic unused_q_1;
    assign unused_q_1 = q_1_i;

endmodule

// File: rtl/booth_multiplicador_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation.
module booth_multiplicador_seq
    import booth_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = booth_clog2(N + 2)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   multiplicando,
    input  logic [N-1:0]   multiplicador,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] producto
);

    logic [N:0]     a_q, a_d, q_q, q_d, m_q, m_d;
    logic           q1_q, q1_d;
    logic [N-1:0]   mcand_q, mcand_d, mplier_q, mplier_d;
    logic           smode_q, smode_d;
    logic [2*N-1:0] prod_q, prod_d;
    logic           listo, carga_m, carga_q, carga_a, resta_a, desplaza_aq, ultimo;

    function automatic logic [N:0] extend(input logic [N-1:0] x, input logic s);
        return {s & x[N-1], x};
    endfunction

    unidad_control_booth #(.N(N), .CW(CW)) u_ctrl (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start),
        .q_lsb_i       (q_q[1:0]),
        .q_1_i         (q1_q),
        .mplier_b0_i   (mplier_q[0]),
        .listo_o       (listo),
        .busy_o        (busy),
        .carga_m_o     (carga_m),
        .carga_q_o     (carga_q),
        .carga_a_o     (carga_a),
        .resta_a_o     (resta_a),
        .desplaza_aq_o (desplaza_aq),
        .ultimo_o      (ultimo),
        .fin_o         (done)
    );

    always_comb begin
        a_d      = a_q;
        q_d      = q_q;
        m_d      = m_q;
        q1_d     = q1_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        smode_d  = smode_q;
        prod_d   = prod_q;
        if (start && listo) begin
            mcand_d  = multiplicando;
            mplier_d = multiplicador;
            smode_d  = signed_mode;
        end
        if (carga_m) m_d = extend(mcand_q, smode_q);
        if (carga_q) begin
            q_d  = extend(mplier_q, smode_q);
            a_d  = '0;
            q1_d = 1'b0;
        end
        if (carga_a) a_d = resta_a ? (a_q - m_q) : (a_q + m_q);
        // Arithmetic right shift of {A, Q, q_1}; the last one also captures the product.
        if (desplaza_aq) begin
            a_d  = {a_q[N], a_q[N:1]};
            q_d  = {a_q[0], q_q[N:1]};
            q1_d = q_q[0];
            if (ultimo) prod_d = {a_d[N-2:0], q_d};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q      <= '0;
            q_q      <= '0;
            m_q      <= '0;
            q1_q     <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            smode_q  <= 1'b0;
            prod_q   <= '0;
        end else begin
            a_q      <= a_d;
            q_q      <= q_d;
            m_q      <= m_d;
            q1_q     <= q1_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            smode_q  <= smode_d;
            prod_q   <= prod_d;
        end
    end

    assign producto = prod_q;

endmodule
